// File: rtl/sb_stream_source.sv
// sb_stream_source
//
// Switchboard stream traffic generator. On an accepted start it emits
// NUM_WORDS counter-valued payload words (seed, seed+1, ... mod 2^64 in the
// low 64 bits, upper bits zero), framed into packets of BURST_LEN words via
// 'last'. It then sends one all-ones terminator word and parks in DONE.
//
// Parameters
//   DW        data width (>= 128 so a payload word never equals the terminator)
//   DESTW     dest width
//   NUM_WORDS payload words per run (>= 1)
//   BURST_LEN words per packet (>= 1)
//
// Ports
//   clk        rising-edge clock
//   nreset     asynchronous active-low reset; aborts a run immediately
//   start      one-cycle run request, honoured only in IDLE or DONE
//   seed       first payload value, captured on accepted start
//   dest_base  dest for the whole run, captured on accepted start
//   data       stream data
//   dest       stream dest
//   last       end-of-packet marker
//   valid      beat present
//   ready      sink accepts the beat
//   busy       high while sending payload or terminator
//   done       high once the terminator has been accepted
//
// All outputs are registered, so valid never depends combinationally on ready.

module sb_stream_source #(
  parameter int DW        = 256,
  parameter int DESTW     = 32,
  parameter int NUM_WORDS = 16,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [63:0]      seed,
  input  logic [DESTW-1:0] dest_base,
  output logic [DW-1:0]    data,
  output logic [DESTW-1:0] dest,
  output logic             last,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);

  // Counters are sized one bit wider than strictly needed so that the
  // incremented value after the final word never aliases back to zero.
  localparam int KW = $clog2(NUM_WORDS + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

  // A one-word run or one-word packets make the very first beat a 'last'.
  localparam logic FIRST_LAST = (NUM_WORDS == 1) || (BURST_LEN == 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    TERM,
    DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [BW-1:0]   b;
  logic [63:0]     seed_q;

  logic            hs;
  logic [KW-1:0]   k_next;
  logic [BW-1:0]   b_next;
  logic            last_next;

  function automatic logic [DW-1:0] payload(input logic [63:0] word);
    return {{(DW-64){1'b0}}, word};
  endfunction

  // Index of the beat that follows the current one once it is accepted.
  // The burst counter restarts after any beat that carried 'last'.
  always_comb begin
    hs        = valid && ready;
    k_next    = k + KW'(1);
    b_next    = last ? '0 : b + BW'(1);
    last_next = (b_next == B_LAST) || (k_next == K_LAST);
  end

  // Data, dest and last are only rewritten on a handshake (or on start, when
  // valid is low), which keeps the beat stable while the sink stalls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      k      <= '0;
      b      <= '0;
      seed_q <= '0;
      data   <= '0;
      dest   <= '0;
      last   <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= SEND;
            seed_q <= seed;
            dest   <= dest_base;
            k      <= '0;
            b      <= '0;
            data   <= payload(seed);
            last   <= FIRST_LAST;
            valid  <= 1'b1;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end

        SEND: begin
          if (hs) begin
            k <= k_next;
            b <= b_next;
            if (k == K_LAST) begin
              state <= TERM;
              data  <= '1;
              last  <= 1'b1;
            end else begin
              data <= payload(seed_q + 64'(k_next));
              last <= last_next;
            end
          end
        end

        TERM: begin
          if (hs) begin
            state <= DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            last  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_stream_source.sv
// tb_sb_stream_source
//
// Directed bench for sb_stream_source. Three instances cover the different
// run lengths: u0 (8 words, packets of 4), u1 (5 words, packets of 4, short
// final packet) and u2 (4 words, used for the 64-bit wrap case).

module tb_sb_stream_source;

  localparam int NU = 3;

  logic         clk;
  logic         nreset_r  [NU];
  logic         start_r   [NU];
  logic [63:0]  seed_r    [NU];
  logic [31:0]  dest_r    [NU];
  logic         ready_r   [NU];
  logic [255:0] data_w    [NU];
  logic [31:0]  dest_w    [NU];
  logic         last_w    [NU];
  logic         valid_w   [NU];
  logic         busy_w    [NU];
  logic         done_w    [NU];

  int tests_run;
  int tests_failed;

  sb_stream_source #(.DW(256), .DESTW(32), .NUM_WORDS(8), .BURST_LEN(4)) u0 (
    .clk(clk), .nreset(nreset_r[0]), .start(start_r[0]), .seed(seed_r[0]),
    .dest_base(dest_r[0]), .data(data_w[0]), .dest(dest_w[0]), .last(last_w[0]),
    .valid(valid_w[0]), .ready(ready_r[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  sb_stream_source #(.DW(256), .DESTW(32), .NUM_WORDS(5), .BURST_LEN(4)) u1 (
    .clk(clk), .nreset(nreset_r[1]), .start(start_r[1]), .seed(seed_r[1]),
    .dest_base(dest_r[1]), .data(data_w[1]), .dest(dest_w[1]), .last(last_w[1]),
    .valid(valid_w[1]), .ready(ready_r[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  sb_stream_source #(.DW(256), .DESTW(32), .NUM_WORDS(4), .BURST_LEN(4)) u2 (
    .clk(clk), .nreset(nreset_r[2]), .start(start_r[2]), .seed(seed_r[2]),
    .dest_base(dest_r[2]), .data(data_w[2]), .dest(dest_w[2]), .last(last_w[2]),
    .valid(valid_w[2]), .ready(ready_r[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns one step after the sampling edge.
  task automatic applyStimulus(input int u, input logic [63:0] sd,
                               input logic [31:0] dst);
    seed_r[u]  = sd;
    dest_r[u]  = dst;
    start_r[u] = 1'b1;
    step();
    start_r[u] = 1'b0;
  endtask

  // Walks one run beat by beat. Each cycle the visible beat must match the
  // expected word, so any change while stalled, any drop or any duplicate
  // shows up as a data/last/valid error. Optionally pulses start (with a
  // different seed/dest) at beat 2 and during the terminator.
  task automatic runAndCheck(input int u, input logic [63:0] sd, input int nw,
                             input int bl, input logic [31:0] dst,
                             input bit rand_ready, input bit inject_start);
    int           beat;
    int           cycles;
    bit           rdy;
    logic [255:0] exp_data;
    logic         exp_last;
    logic [63:0]  word;
    beat   = 0;
    cycles = 0;
    while (beat <= nw && cycles < 200) begin
      if (beat < nw) begin
        word     = sd + 64'(beat);
        exp_data = {192'b0, word};
        exp_last = ((beat % bl) == bl - 1) || (beat == nw - 1);
      end else begin
        exp_data = '1;
        exp_last = 1'b1;
      end
      checkOutput($sformatf("u%0d valid b%0d", u, beat), valid_w[u], 1'b1);
      checkOutput($sformatf("u%0d data b%0d", u, beat), data_w[u], exp_data);
      checkOutput($sformatf("u%0d last b%0d", u, beat), last_w[u], exp_last);
      checkOutput($sformatf("u%0d dest b%0d", u, beat), dest_w[u], dst);
      checkOutput($sformatf("u%0d busy b%0d", u, beat), busy_w[u], 1'b1);
      checkOutput($sformatf("u%0d done b%0d", u, beat), done_w[u], 1'b0);
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_r[u] = rdy;
      if (inject_start && (beat == 2 || beat == nw)) begin
        start_r[u] = 1'b1;
        seed_r[u]  = 64'hDEAD_BEEF_0000_0000;
        dest_r[u]  = 32'h1234_5678;
      end
      step();
      start_r[u] = 1'b0;
      if (rdy) beat++;
      cycles++;
    end
    checkOutput($sformatf("u%0d beats seen", u), beat, nw + 1);
    checkOutput($sformatf("u%0d done end", u), done_w[u], 1'b1);
    checkOutput($sformatf("u%0d busy end", u), busy_w[u], 1'b0);
    checkOutput($sformatf("u%0d valid end", u), valid_w[u], 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int u = 0; u < NU; u++) begin
      nreset_r[u] = 1'b0;
      start_r[u]  = 1'b0;
      seed_r[u]   = '0;
      dest_r[u]   = '0;
      ready_r[u]  = 1'b1;
    end

    // Reset values on every instance.
    #1;
    for (int u = 0; u < NU; u++) begin
      checkOutput($sformatf("u%0d rst data", u), data_w[u], '0);
      checkOutput($sformatf("u%0d rst dest", u), dest_w[u], '0);
      checkOutput($sformatf("u%0d rst last", u), last_w[u], 1'b0);
      checkOutput($sformatf("u%0d rst valid", u), valid_w[u], 1'b0);
      checkOutput($sformatf("u%0d rst busy", u), busy_w[u], 1'b0);
      checkOutput($sformatf("u%0d rst done", u), done_w[u], 1'b0);
    end
    step();
    for (int u = 0; u < NU; u++) nreset_r[u] = 1'b1;
    step();
    checkOutput("u0 idle valid", valid_w[0], 1'b0);

    // Basic run: 0x100..0x107, last on 0x103 and 0x107, then terminator.
    applyStimulus(0, 64'h100, 32'h5555);
    runAndCheck(0, 64'h100, 8, 4, 32'h5555, 1'b0, 1'b0);

    // DONE holds without start.
    step();
    step();
    checkOutput("u0 done hold", done_w[0], 1'b1);
    checkOutput("u0 done valid", valid_w[0], 1'b0);

    // Restart from DONE with seed 0x200, with ignored start pulses mid-run.
    applyStimulus(0, 64'h200, 32'h6666);
    runAndCheck(0, 64'h200, 8, 4, 32'h6666, 1'b0, 1'b1);

    // Backpressure with a random ready pattern.
    applyStimulus(0, 64'h100, 32'h5555);
    runAndCheck(0, 64'h100, 8, 4, 32'h5555, 1'b1, 1'b0);

    // Short final packet: last on k=3 and k=4.
    applyStimulus(1, 64'h40, 32'hBEEF);
    runAndCheck(1, 64'h40, 5, 4, 32'hBEEF, 1'b0, 1'b0);

    // 64-bit wrap: FFFE, FFFF, 0, 1.
    applyStimulus(2, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0F0F);
    runAndCheck(2, 64'hFFFF_FFFF_FFFF_FFFE, 4, 4, 32'h0F0F, 1'b1, 1'b0);

    // Reset mid-burst at k=2, then a fresh run from seed 0x10.
    ready_r[0] = 1'b1;
    applyStimulus(0, 64'h300, 32'hAAAA);
    step();
    step();
    checkOutput("u0 k2 data", data_w[0], {192'b0, 64'h302});
    checkOutput("u0 k2 valid", valid_w[0], 1'b1);
    nreset_r[0] = 1'b0;
    #1;
    checkOutput("u0 abort valid", valid_w[0], 1'b0);
    checkOutput("u0 abort busy", busy_w[0], 1'b0);
    checkOutput("u0 abort done", done_w[0], 1'b0);
    checkOutput("u0 abort data", data_w[0], '0);
    step();
    nreset_r[0] = 1'b1;
    step();
    applyStimulus(0, 64'h10, 32'h77);
    runAndCheck(0, 64'h10, 8, 4, 32'h77, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sb_stream_source.md
# sb_stream_source

Switchboard stream traffic generator. It drives the TX side of an SB stream link: data, dest, last, valid out, and ready in. On a start pulse it emits a framed sequence of counter-valued words, then sends the all-ones terminator word, which downstream testbenches use as the `$finish` condition. It sits in front of an SB TX port (or a DUT input) as the producing end for stream-processing blocks and their loopback benches.

## Interface
- DW, 256: data width; must be >= 128 so a payload word can never equal the terminator.
- DESTW, 32: dest width.
- NUM_WORDS, 16: payload words per run, >= 1.
- BURST_LEN, 4: words per packet (last framing), >= 1.

- clk  in  1  clock; all state updates on the rising edge.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE or DONE.
- seed  in  64  first payload value; captured on accepted start.
- dest_base  in  DESTW  dest value for the whole run; captured on accepted start.
- data  out  DW  stream data.
- dest  out  DESTW  stream dest.
- last  out  1  end-of-packet marker.
- valid  out  1  beat present.
- ready  in  1  sink accepts the beat.
- busy  out  1  high in SEND or TERM.
- done  out  1  high in DONE.

## Operation
- FSM states: IDLE, SEND, TERM, DONE.
- IDLE or DONE with start=1 -> SEND:
  - capture seed and dest_base;
  - clear word counter k and burst counter b.
- SEND, one beat per word:
  - data[63:0] = seed + k, mod 2^64 (wraps);
  - data[DW-1:64] = 0;
  - dest = captured dest_base;
  - last = 1 when b == BURST_LEN-1 or k == NUM_WORDS-1, else 0.
- Handshake occurs when valid && ready:
  - k increments;
  - b increments, or returns to 0 if last was 1.
  - If the beat was k == NUM_WORDS-1, go to TERM.
- TERM:
  - data = all ones (DW bits), last = 1, dest = captured dest_base.
  - Handshake -> DONE.
- DONE:
  - valid = 0, done = 1.
  - Stays in DONE until start.
- start while in SEND or TERM is ignored; no restart, no capture.
- All outputs are registered.
- Reset values:
  - data = 0, dest = 0, last = 0, valid = 0, busy = 0, done = 0;
  - state = IDLE; counters = 0.
- Asserting nreset mid-run aborts immediately (asynchronous):
  - valid drops without a handshake; this is the only permitted exception to the stream rules below.
  - There is no resume; the next start begins at k = 0.

## Timing
- start sampled at edge N -> valid = 1 with the first word after edge N (visible in cycle N+1).
- With ready held at 1: one beat per cycle.
  - NUM_WORDS payload beats, then 1 terminator beat.
  - done = 1 the cycle after the terminator handshake.
- Stream rules, enforced by the block:
  - once valid = 1, data, dest and last stay stable until the handshake;
  - valid never deasserts before the handshake;
  - valid does not depend combinationally on ready.
- Next word appears in the cycle after a handshake, so there are no bubbles while ready = 1.
- Start accepted in DONE: done clears and valid rises on the same edge.

## Test plan
- Basic run, NUM_WORDS=8, BURST_LEN=4, seed=0x100, dest_base=0x5555, ready=1:
  - 8 beats with data[63:0] = 0x100..0x107 on consecutive cycles, upper bits 0, dest 0x5555;
  - last=1 on the beats with 0x103 and 0x107;
  - 9th beat is all ones with last=1;
  - done=1 next cycle; busy=0.
- Backpressure, same configuration, ready driven by a random 50% pattern:
  - identical beat sequence; no drops and no duplicates;
  - outputs stable every cycle where valid && !ready.
- Partial final packet, NUM_WORDS=5, BURST_LEN=4:
  - last=1 on k=3 and on k=4, where the final packet is 1 word;
  - then the terminator.
- Wrap, seed=0xFFFF_FFFF_FFFF_FFFE, NUM_WORDS=4:
  - data[63:0] = FFFF_FFFF_FFFF_FFFE, FFFF_FFFF_FFFF_FFFF, 0, 1;
  - no payload word equals the terminator.
- Reset mid-burst: drop nreset during k=2 with valid=1:
  - valid, busy, done = 0 immediately;
  - after release plus start with seed=0x10, first beat data[63:0] = 0x10.
- Start handling:
  - start pulses during SEND are ignored; the sequence and captured dest_base are unchanged;
  - start in DONE with seed=0x200 reruns from 0x200 and clears done.
